// File: rtl/ne16_normquant_param_loader.sv
// ne16_normquant_param_loader
//   Producer side of the normquant parameter interface. Unpacks a 32-bit
//   stream of normalization multipliers followed by shift amounts into
//   per-channel registers and presents the complete set to the normquant
//   array with a valid/ack handshake. One set is loaded per output tile.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   clear_i          synchronous local clear, same effect as rst_i
//   start_i          begin loading a set (only honoured in IDLE)
//   nb_chan_i        number of valid channels, clamped to NCH on start
//   skip_mult_i      stream carries no multipliers, all mults forced to 1
//   stream_*         incoming parameter words (valid/ready)
//   norm_mult_o      NCH packed multipliers, channel c at [c*NMS +: NMS]
//   shift_o          NCH packed shift amounts, channel c at [c*8 +: 8]
//   params_valid_o   set complete and stable until params_ack_i
//   busy_o           loader is not idle
module ne16_normquant_param_loader #(
    parameter int NMULT = 4,
    parameter int NCOL  = 16,
    parameter int NMS   = 8,
    parameter int DW    = 32,
    parameter int NCH   = NCOL * NMULT,
    parameter int CW    = $clog2(NCH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic [CW-1:0]       nb_chan_i,
    input  logic                skip_mult_i,
    input  logic [DW-1:0]       stream_data_i,
    input  logic                stream_valid_i,
    output logic                stream_ready_o,
    output logic [NCH*NMS-1:0]  norm_mult_o,
    output logic [NCH*8-1:0]    shift_o,
    output logic                params_valid_o,
    input  logic                params_ack_i,
    output logic                busy_o
);

    // Sub-fields carried by one stream beat in each load phase.
    localparam int MPB = DW / NMS;
    localparam int SPB = DW / 8;
    localparam logic [NMS-1:0] MULT_ONE = {{(NMS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_MULT  = 2'd1,
        ST_LOAD_SHIFT = 2'd2,
        ST_VALID      = 2'd3
    } state_e;

    state_e                       state_r;
    state_e                       state_next_s;
    logic [CW-1:0]                nb_r;
    logic [CW-1:0]                nb_clamp_s;
    logic [CW-1:0]                beat_r;
    logic [CW-1:0]                mult_words_s;
    logic [CW-1:0]                shift_words_s;
    logic                         start_accept_s;
    logic                         beat_accept_s;
    logic                         last_beat_s;
    logic                         stream_ready_s;
    logic [NCH-1:0][NMS-1:0]      mult_r;
    logic [NCH-1:0][7:0]          shift_r;
    logic                         params_valid_r;
    logic                         busy_r;

    // Number of DW-bit words needed to carry nb fields of field_w bits.
    function automatic logic [CW-1:0] word_count(input logic [CW-1:0] nb,
                                                 input int field_w);
        int bits;
        bits = int'(nb) * field_w;
        return CW'((bits + DW - 1) / DW);
    endfunction

    assign nb_clamp_s     = (nb_chan_i > CW'(NCH)) ? CW'(NCH) : nb_chan_i;
    assign mult_words_s   = word_count(nb_r, NMS);
    assign shift_words_s  = word_count(nb_r, 8);
    assign stream_ready_s = (state_r == ST_LOAD_MULT) || (state_r == ST_LOAD_SHIFT);
    assign start_accept_s = (state_r == ST_IDLE) && start_i;
    assign beat_accept_s  = stream_ready_s && stream_valid_i;

    // Detect the final beat of the current load phase.
    always_comb begin
        last_beat_s = 1'b0;
        if (state_r == ST_LOAD_MULT) begin
            last_beat_s = (beat_r == (mult_words_s - CW'(1)));
        end else if (state_r == ST_LOAD_SHIFT) begin
            last_beat_s = (beat_r == (shift_words_s - CW'(1)));
        end else begin
            last_beat_s = 1'b0;
        end
    end

    // Next-state logic of the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (nb_clamp_s == '0) begin
                        state_next_s = ST_VALID;
                    end else if (skip_mult_i) begin
                        state_next_s = ST_LOAD_SHIFT;
                    end else begin
                        state_next_s = ST_LOAD_MULT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD_MULT: begin
                if (beat_accept_s && last_beat_s) begin
                    state_next_s = ST_LOAD_SHIFT;
                end else begin
                    state_next_s = ST_LOAD_MULT;
                end
            end
            ST_LOAD_SHIFT: begin
                if (beat_accept_s && last_beat_s) begin
                    state_next_s = ST_VALID;
                end else begin
                    state_next_s = ST_LOAD_SHIFT;
                end
            end
            ST_VALID: begin
                if (params_ack_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_VALID;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_r        <= ST_IDLE;
            params_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            params_valid_r <= (state_next_s == ST_VALID);
            busy_r         <= (state_next_s != ST_IDLE);
        end
    end

    // Channel count latch and beat counter; counter restarts between phases.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            nb_r   <= '0;
            beat_r <= '0;
        end else if (start_accept_s) begin
            nb_r   <= nb_clamp_s;
            beat_r <= '0;
        end else if (beat_accept_s) begin
            if (last_beat_s) begin
                beat_r <= '0;
            end else begin
                beat_r <= beat_r + CW'(1);
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    // Multiplier registers: seeded on start, filled field by field in LOAD_MULT.
    // Channels at or above nb never match and keep their seed value.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            mult_r <= '0;
        end else if (start_accept_s) begin
            for (int c = 0; c < NCH; c++) begin
                mult_r[c] <= skip_mult_i ? MULT_ONE : '0;
            end
        end else if (beat_accept_s && (state_r == ST_LOAD_MULT)) begin
            for (int c = 0; c < NCH; c++) begin
                if ((beat_r == CW'(c / MPB)) && (CW'(c) < nb_r)) begin
                    mult_r[c] <= stream_data_i[(c % MPB) * NMS +: NMS];
                end
            end
        end else begin
            mult_r <= mult_r;
        end
    end

    // Shift registers: cleared on start, filled field by field in LOAD_SHIFT.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            shift_r <= '0;
        end else if (start_accept_s) begin
            shift_r <= '0;
        end else if (beat_accept_s && (state_r == ST_LOAD_SHIFT)) begin
            for (int c = 0; c < NCH; c++) begin
                if ((beat_r == CW'(c / SPB)) && (CW'(c) < nb_r)) begin
                    shift_r[c] <= stream_data_i[(c % SPB) * 8 +: 8];
                end
            end
        end else begin
            shift_r <= shift_r;
        end
    end

    assign stream_ready_o = stream_ready_s;
    assign norm_mult_o    = mult_r;
    assign shift_o        = shift_r;
    assign params_valid_o = params_valid_r;
    assign busy_o         = busy_r;

endmodule

// File: doc/ne16_normquant_param_loader.md
Name: ne16_normquant_param_loader

Overview:
- Producer side of the normquant parameter interface: receives normalization multipliers and shift amounts as a 32-bit stream from the streamer and unpacks them into per-channel registers.
- Presents the full parameter vectors (norm_mult, shift) to the NCOL normquant instances with a valid/ack handshake.
- Sits between the source streamer and the accumulator/normquant array; one full parameter set is loaded per output tile.

Parameters:
NMULT, 4, channels per normquant instance
NCOL, 16, number of normquant instances fed
NMS, 8, multiplier width in bits; must divide DW
DW, 32, stream data width
NCH, NCOL*NMULT (64), total channel slots (derived)
CW, $clog2(NCH+1) (7), width of nb_chan_i (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
clear_i  in  1  synchronous local clear; same effect as rst_i
start_i  in  1  begin loading a parameter set; sampled only in IDLE
nb_chan_i  in  CW  number of valid channels; latched on accepted start
skip_mult_i  in  1  no multiplier words in stream; all multipliers forced to 1; latched on start
stream_data_i  in  DW  packed parameter word
stream_valid_i  in  1  stream word valid
stream_ready_o  out  1  loader accepts word
norm_mult_o  out  NCH*NMS  channel c at bits [(c+1)*NMS-1:c*NMS]
shift_o  out  NCH*8  channel c at bits [(c+1)*8-1:c*8]
params_valid_o  out  1  parameter set complete and stable
params_ack_i  in  1  consumer has taken the set
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset and clear: state IDLE; all mult and shift registers 0; all outputs 0.
- Latching on accepted start (IDLE and start_i):
  - nb_chan_i is latched; values above NCH clamp to NCH.
  - Mult registers are set to 0, or to 1 if skip_mult_i.
  - Shift registers are set to 0.
  - Beat counter is cleared.
- Word counts:
  - MW = ceil(nb*NMS/DW) multiplier words (4 for nb=16, NMS=8).
  - SW = ceil(nb*8/DW) shift words.
- FSM:
  - IDLE -> LOAD_MULT on start when nb>0 and skip_mult=0.
  - IDLE -> LOAD_SHIFT on start when nb>0 and skip_mult=1.
  - IDLE -> VALID on start when nb=0.
  - LOAD_MULT -> LOAD_SHIFT the cycle after beat MW-1 is accepted; the beat counter is reset at this transition.
  - LOAD_SHIFT -> VALID the cycle after beat SW-1 is accepted.
  - VALID -> IDLE the cycle after params_ack_i=1.
- stream_ready_o: combinational, 1 exactly in LOAD_MULT and LOAD_SHIFT. A beat is accepted when stream_valid_i and stream_ready_o are both 1.
- Unpacking, beat k:
  - Sub-field j (LSB first) writes channel k*(DW/NMS)+j in LOAD_MULT, or channel k*4+j in LOAD_SHIFT.
  - Sub-fields addressing channel >= nb are discarded; that channel keeps 0, or 1 for mults when skip_mult.
- params_valid_o: registered, 1 exactly in VALID; rises one cycle after the last accepted beat.
- busy_o: registered, 1 in any state other than IDLE.
- Stability:
  - norm_mult_o and shift_o are driven directly from the registers.
  - They are constant throughout VALID.
  - After ack they hold their values until the next accepted start.
- Stream valid gaps: any number of idle cycles between beats is allowed; the counter advances only on accepted beats.
- Ignored inputs:
  - start_i outside IDLE is ignored, including start together with ack in VALID; a new start requires IDLE.
  - params_ack_i outside VALID is ignored.
- clear_i or rst_i mid-load: the next cycle is IDLE with registers zeroed; a partially accepted set is discarded; stream_ready_o is 0 that cycle.
- Simultaneous clear_i and start_i: clear wins and start is dropped.
- Extra stream words: words beyond MW+SW are not consumed because stream_ready_o=0 outside the LOAD states.

Test Plan:
- Full 8-bit set: nb=64, skip=0, 16 mult words then 16 shift words, valid every cycle. Expect stream_ready_o for exactly 32 cycles and params_valid_o on cycle 33. Expect norm_mult_o channel c = byte c of the mult stream and shift_o channel c = byte c of the shift stream. Ack then returns to IDLE, with busy_o=0 the following cycle.
- Partial set: nb=6, mult words 0x04030201 and 0x08070605; shift words 0x0B0A0908 and 0x0F0E0D0C. Expect mult ch0..5 = 1..6, ch6,7 = 0, shift ch0..5 = 8..13, ch6.. = 0.
- skip_mult=1, nb=8: only 2 shift words are accepted. All 64 mult channels = 1; shift ch0..7 as streamed.
- Backpressure and gaps: stream_valid_i toggles 1,0,0,1 per beat. Expect the same final vectors as the gap-free run and params_valid_o one cycle after the last beat. start_i pulsed during LOAD is ignored (state unchanged).
- Abort: clear_i after 3 of 16 mult beats. Expect IDLE next cycle, all outputs 0, stream_ready_o=0. A subsequent start with nb=4 loads correctly.
- nb=0 and clamp: nb=0 goes IDLE->VALID in one cycle with zero outputs and no beats accepted. nb=100 behaves identically to nb=64 (32 beats).
